// File: rtl/display_pkg.sv
// Shared constants for the 4-digit multiplexed result display:
// segment patterns, digit indices and digit-enable codes.
package display_pkg;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } digit_e;

   typedef struct packed {
      logic [2:0] sum;
      logic       carry_out;
      logic       mode;
      logic       overflow;
   } snap_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_S     = 7'b0010010;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_O     = 7'b0100011;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [3:0] AN_D0  = 4'b1110;
   localparam logic [3:0] AN_D1  = 4'b1101;
   localparam logic [3:0] AN_D2  = 4'b1011;
   localparam logic [3:0] AN_D3  = 4'b0111;

   // Widened to 4 bits so that -4 yields 4 rather than wrapping.
   function automatic logic [3:0] magnitude(input logic [2:0] s);
      logic [3:0] sx;
      sx = {s[2], s};
      return s[2] ? (~sx + 4'd1) : sx;
   endfunction

   function automatic logic [6:0] digit_seg(input logic [3:0] v);
      logic [6:0] p;
      p = SEG_BLANK;
      case (v)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/display_timebase.sv
// Dwell counter, digit scan index and frame-rate blink generator
// for the multiplexed display.
module display_timebase
   import display_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned BLINK_FRAMES = 125
) (
   input  logic   clk,
   input  logic   rst_n,
   output digit_e digit_idx,
   output logic   frame_tick,
   output logic   blink_on
);

   localparam int unsigned DW =
      (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned FW =
      (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [DW-1:0] dwell;
   logic [FW-1:0] frame_cnt;
   logic          dwell_wrap;

   assign dwell_wrap = (dwell == DWELL_LAST);
   assign frame_tick = dwell_wrap && (digit_idx == DIG3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell     <= '0;
         digit_idx <= DIG0;
         frame_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         dwell <= dwell_wrap ? '0 : dwell + 1'b1;
         if (dwell_wrap)
            digit_idx <= digit_e'(digit_idx + 2'd1);
         if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
               frame_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/result_display_mux.sv
// Shows the adder/subtractor result on a 4-digit common-anode display,
// with inputs frozen for a whole scan frame.
module result_display_mux
   import display_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sum,
   input  logic       carry_out,
   input  logic       mode,
   input  logic       overflow,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   digit_e     digit_idx;
   logic       frame_tick;
   logic       blink_on;
   snap_t      snap;
   logic [3:0] an_d;
   logic [6:0] seg_d;
   logic       dp_d;

   display_timebase #(
      .DWELL_CYCLES(DWELL_CYCLES),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_timebase (
      .clk       (clk),
      .rst_n     (rst_n),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick),
      .blink_on  (blink_on)
   );

   // Loading only on the frame boundary keeps each frame self-consistent.
   always_ff @(posedge clk) begin
      if (!rst_n)
         snap <= '0;
      else if (frame_tick)
         snap <= {sum, carry_out, mode, overflow};
   end

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      unique case (digit_idx)
         DIG3: begin
            an_d  = AN_D3;
            seg_d = snap.mode ? SEG_S : SEG_A;
         end
         DIG2: begin
            an_d  = AN_D2;
            seg_d = snap.sum[2] ? SEG_DASH : SEG_BLANK;
         end
         DIG1: begin
            an_d  = AN_D1;
            seg_d = digit_seg(magnitude(snap.sum));
         end
         DIG0: begin
            an_d  = AN_D0;
            seg_d = (snap.overflow && blink_on) ? SEG_O : SEG_BLANK;
            dp_d  = ~snap.carry_out;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: doc/result_display_mux.md
Name: result_display_mux

Overview:
- Downstream consumer of the 3-bit adder/subtractor outputs: sum, carry-out, mode and overflow.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Shows the operation, the sign, the signed magnitude, a carry dot and a blinking overflow marker.
- Snapshots its inputs once per refresh frame, so a frame never shows mixed old and new values while switches move.

Parameters:
- DWELL_CYCLES, 100000: clock cycles each digit stays enabled (1 ms at 100 MHz). Legal range is 1 or more.
- BLINK_FRAMES, 125: complete 4-digit frames per overflow-blink half-period. Legal range is 1 or more.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- sum  in  3  adder/subtractor result, 3-bit two's complement (-4..+3).
- carry_out  in  1  carry out of the adder's MSB.
- mode  in  1  0 = add, 1 = subtract.
- overflow  in  1  signed overflow flag.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets the following, both at power-up and mid-operation:
  - dwell=0, digit_idx=0, frame_cnt=0, blink_on=1.
  - snapshot {sum, carry_out, mode, overflow} = 0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1 and then wraps to 0.
  - On each wrap, digit_idx advances 0→1→2→3→0.
- Frame boundary is the cycle where dwell=DWELL_CYCLES-1 and digit_idx=3. On that cycle:
  - The snapshot register loads the current inputs.
  - frame_cnt increments.
  - When frame_cnt=BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
- Outputs are registered with 1-cycle latency from (digit_idx, snapshot, blink_on).
  - Each digit is lit for exactly DWELL_CYCLES consecutive cycles.
  - The first cycle after reset release shows an=4'b1110.
  - Exactly one an bit is low at any time after that.
- Digit content, taken from the snapshot:
  - digit3 (an=0111): 'A' when mode=0, 'S' when mode=1; dp=1.
  - digit2 (an=1011): '-' when sum[2]=1, otherwise blank; dp=1.
  - digit1 (an=1101): magnitude |sum| as a digit 0..4. Sum 3'b100 shows '4'. Magnitude is computed 4 bits wide, so -4 does not wrap. dp=1.
  - digit0 (an=1110): 'o' when overflow=1 and blink_on=1, otherwise blank. dp = ~carry_out.
- Patterns (seg[6:0] = g..a):
  - '0' 1000000, '1' 1111001, '2' 0100100, '3' 0110000, '4' 0011001.
  - 'A' 0001000, 'S' 0010010, '-' 0111111, 'o' 0100011, blank 1111111.
- Input changes between frame boundaries are ignored until the next boundary.
- A change on the boundary cycle itself is captured.
- DWELL_CYCLES=1: the digit advances every cycle and every fourth cycle is a frame boundary.
- Counters never saturate; they wrap exactly as described.

Decomposition:
- Shared package display_pkg holds:
  - the segment pattern constants;
  - the digit-index encoding;
  - the an one-hot constants.
- One sub-module, display_timebase, holds the dwell counter, digit_idx, frame_cnt and blink_on. It outputs digit_idx, frame_tick and blink_on.
- The top level holds the snapshot register and the registered decode.

Test Plan (DWELL_CYCLES=4, BLINK_FRAMES=2):
- Hold rst_n=0 for 3 cycles, then release → an=1111 and seg=1111111 while in reset. The cycle after release shows an=1110, seg=1111111, dp=1. an then steps to 1101, 1011, 0111, 4 cycles each.
- sum=3'b101, mode=1, carry_out=1, overflow=0 applied before a frame boundary → in the following frame:
  - digit3 = 0010010;
  - digit2 = 0111111;
  - digit1 = 0110000 ('3');
  - digit0 blank with dp=0.
- sum=3'b100, mode=0, carry_out=0 → in the next frame digit3 shows 'A', digit2 shows '-', digit1 shows 0011001 ('4').
- overflow=1 held → digit0 seg is 0100011 for 2 frames, then 1111111 for 2 frames, repeating.
- Change sum from 3'b011 to 3'b001 on cycle 2 of digit1's dwell → digit1 still shows '3' for the remainder of that frame and shows '1' from the next frame.
- Assert rst_n=0 for one cycle during digit2's dwell → the next cycle gives an=1111 and snapshot cleared. After release, display shows 'A', blank, '0', blank.
